fmap_buffer: RTL and testbench
==============================

// Module: fmap_buffer
// PURPOSE
//   Feature-map buffer: the memory-side responder for in-place layer engines (relu, pool,
//   conv writeback). Holds CHANNELS*IMG_SIZE*IMG_SIZE signed words.
//   Serves one read port A (1-cycle latency) and one write port B.
//   Built-in clear engine zeroes the array after reset or on request; busy while sweeping.
// PARAMETERS
//   DATA_WIDTH      16  word width, two's complement
//   CHANNELS        1   channel count
//   IMG_SIZE        8   spatial side; N = CHANNELS*IMG_SIZE*IMG_SIZE entries
//   CLEAR_ON_RESET  1   1: clear sweep starts on reset release; 0: array contents undefined, idle
//   (derived) AW = (N<=1) ? 1 : $clog2(N)
// PORTS
//   clk          in   1    clock, all logic on rising edge
//   reset        in   1    asynchronous, active-low reset
//   clear        in   1    1-cycle pulse: zero the whole array
//   busy         out  1    clear sweep in progress; ports ignored
//   conv_r_addr  in   AW   port A read address
//   conv_r_en    in   1    port A read enable
//   conv_r_q     out  DW   port A read data, valid 1 cycle after conv_r_en
//   conv_w_addr  in   AW   port B address
//   conv_w_en    in   1    port B enable
//   conv_w_we    in   1    port B write strobe; write occurs only when conv_w_en && conv_w_we
//   conv_w_d     in   DW   port B write data
//   acc_err      out  1    sticky: illegal access seen (out of range, or during busy)
// BEHAVIOUR
//   Reset (reset==0), applied immediately:
//     conv_r_q=0, acc_err=0, clr_ptr=0.
//     state = CLEAR_ON_RESET ? S_CLEAR : S_IDLE; busy = CLEAR_ON_RESET.
//     Array storage itself is not reset (RAM inference).
//   FSM states:
//     S_IDLE:  normal service. clear=1 -> S_CLEAR next edge, clr_ptr=0, busy=1 from that edge.
//     S_CLEAR: each cycle mem[clr_ptr]<=0, clr_ptr++. The write at clr_ptr==N-1 -> S_IDLE.
//              busy drops on that same edge, so busy is high exactly N cycles.
//              clear=1 while in S_CLEAR restarts the sweep: clr_ptr=0, state stays S_CLEAR.
//   Read: conv_r_en=1 at edge k with addr<N and !busy -> conv_r_q=mem[addr] at edge k.
//     conv_r_q holds its value while conv_r_en=0.
//   Write: conv_w_en&&conv_w_we, addr<N, !busy -> mem[addr]<=conv_w_d at that edge.
//     conv_w_en=1 with conv_w_we=0 is a no-op and is not an error.
//   Out of range (addr>=N, possible when N is not a power of 2):
//     read -> conv_r_q<=0; write dropped; acc_err<=1.
//   Access while busy: read -> conv_r_q<=0; write dropped; acc_err<=1.
//     Clear-engine writes always win.
//   Same-address read+write in one cycle: see CONFIGURATION.
//   Different addresses in the same cycle: fully independent, no stall.
//   acc_err clears only on reset; clear does not reset it.
//   No arithmetic; data passed through unmodified at DATA_WIDTH.
// CONFIGURATION
//   FMAP_BYPASS_EN undefined (default): read-first.
//     Same-address same-cycle read returns the OLD word; infers plain simple dual-port BRAM.
//   FMAP_BYPASS_EN defined: write-first.
//     Same-address read returns conv_w_d, via a registered forward mux around the RAM output.
//   No other behaviour differs between the two builds.
// TESTING
//   1 Reset release, CLEAR_ON_RESET=1, N=64:
//     busy high exactly 64 cycles; afterwards all 64 reads return 0; acc_err=0.
//   2 Write 0x7FFF @5, 0x8000 @6, then read 5,6 back-to-back:
//     conv_r_q=0x7FFF then 0x8000, each 1 cycle after conv_r_en.
//   3 C=3, SZ=5 (N=75, AW=7): write @80 then read @80:
//     mem[0..74] unchanged, conv_r_q=0, acc_err=1.
//   4 mem[9]=3; same cycle: write 9<=-4 and read 9.
//     Default build: q=3. FMAP_BYPASS_EN build: q=-4. Next read of 9 returns -4 in both.
//   5 clear pulse, second clear 10 cycles later:
//     busy high 10+64 cycles; a write issued during busy is dropped and sets acc_err; array all 0.
//   6 Attach relu (DW=16, C=1, SZ=8), seed mem[i] = (i%3==0)?-i:(i%3==1)?0:i, run to done:
//     mem[i] == max(v,0) for all 64 entries; acc_err=0.

Source files
------------

// File: rtl/fmap_buffer_if.sv
// Feature-map buffer bus: control, read port A, write port B and status.
// The master side is the layer engine, the slave side is fmap_buffer.
interface fmap_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  clear;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] conv_r_addr;
    logic                  conv_r_en;
    logic [DATA_WIDTH-1:0] conv_r_q;
    logic [ADDR_WIDTH-1:0] conv_w_addr;
    logic                  conv_w_en;
    logic                  conv_w_we;
    logic [DATA_WIDTH-1:0] conv_w_d;
    logic                  acc_err;

    modport master (
        output clear, conv_r_addr, conv_r_en, conv_w_addr, conv_w_en, conv_w_we, conv_w_d,
        input  busy, conv_r_q, acc_err
    );

    modport slave (
        input  clear, conv_r_addr, conv_r_en, conv_w_addr, conv_w_en, conv_w_we, conv_w_d,
        output busy, conv_r_q, acc_err
    );
endinterface

// File: rtl/fmap_buffer.sv
// Feature-map buffer: CHANNELS*IMG_SIZE*IMG_SIZE signed words, one registered
// read port (A) and one write port (B), plus a clear engine that zeroes the
// whole array after reset (CLEAR_ON_RESET) or on a clear pulse.
// Build option: define FMAP_BYPASS_EN for write-first same-address behaviour;
// left undefined the RAM is read-first (returns the old word).
module fmap_buffer #(
    parameter int DATA_WIDTH     = 16,
    parameter int CHANNELS       = 1,
    parameter int IMG_SIZE       = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         reset,
    fmap_buffer_if.slave bus
);
    localparam int N  = CHANNELS * IMG_SIZE * IMG_SIZE;
    localparam int AW = (N <= 1) ? 1 : $clog2(N);
    // One bit wider than the address so N itself is representable.
    localparam logic [AW:0]   N_L  = (AW + 1)'(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                state_reg;
    logic                  busy_reg;
    logic [AW-1:0]         clr_ptr_reg;
    logic                  acc_err_reg;
    logic [DATA_WIDTH-1:0] conv_r_q_reg;
    logic [DATA_WIDTH-1:0] mem [N];

    logic r_req;
    logic w_req;
    logic r_in_range;
    logic w_in_range;
    logic r_ok;
    logic w_ok;
    logic r_bad;
    logic w_bad;
    logic fwd_hit;

    // An enabled port without the write strobe is not an access at all.
    assign r_req      = bus.conv_r_en;
    assign w_req      = bus.conv_w_en & bus.conv_w_we;
    assign r_in_range = ({1'b0, bus.conv_r_addr} < N_L);
    assign w_in_range = ({1'b0, bus.conv_w_addr} < N_L);
    assign r_ok       = r_req & ~busy_reg & r_in_range;
    assign w_ok       = w_req & ~busy_reg & w_in_range;
    assign r_bad      = r_req & ~r_ok;
    assign w_bad      = w_req & ~w_ok;

`ifdef FMAP_BYPASS_EN
    // Write-first: a same-address read sees the word being written this cycle.
    assign fwd_hit = w_ok & (bus.conv_w_addr == bus.conv_r_addr);
`else
    // Read-first: the RAM output always carries the pre-write word.
    assign fwd_hit = 1'b0;
`endif

    // Clear-engine FSM: sweeps clr_ptr over every entry; a clear pulse restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            busy_reg    <= (CLEAR_ON_RESET != 0);
            clr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.clear) begin
                        state_reg   <= S_CLEAR;
                        busy_reg    <= 1'b1;
                        clr_ptr_reg <= '0;
                    end
                end
                S_CLEAR: begin
                    if (bus.clear) begin
                        clr_ptr_reg <= '0;
                    end else if (clr_ptr_reg == LAST) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port: the clear engine owns the array while busy.
    always_ff @(posedge clk) begin
        if (busy_reg) begin
            mem[clr_ptr_reg] <= '0;
        end else if (w_ok) begin
            mem[bus.conv_w_addr] <= bus.conv_w_d;
        end
    end

    // Registered read data: holds when idle, zero on a refused read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conv_r_q_reg <= '0;
        end else if (r_ok) begin
            conv_r_q_reg <= fwd_hit ? bus.conv_w_d : mem[bus.conv_r_addr];
        end else if (r_bad) begin
            conv_r_q_reg <= '0;
        end
    end

    // Sticky illegal-access flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_err_reg <= 1'b0;
        end else if (r_bad | w_bad) begin
            acc_err_reg <= 1'b1;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.conv_r_q = conv_r_q_reg;
    assign bus.acc_err  = acc_err_reg;

endmodule

// File: tb/tb_fmap_buffer.sv
// Testbench for fmap_buffer: a 64-entry instance (main checks, clear timing,
// relu-style in-place pass, random traffic against an array model) and a
// 75-entry instance for out-of-range accesses.
module tb_fmap_buffer;
    localparam int DW = 16;
`ifdef FMAP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fmap_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(6)) bus_a ();
    fmap_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(7)) bus_b ();

    fmap_buffer #(.DATA_WIDTH(DW), .CHANNELS(1), .IMG_SIZE(8), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    fmap_buffer #(.DATA_WIDTH(DW), .CHANNELS(3), .IMG_SIZE(5), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] model [64];
    logic [DW-1:0] q_exp;

    typedef struct {
        bit            w_en;
        bit            w_we;
        logic [5:0]    w_addr;
        logic [DW-1:0] w_d;
        bit            r_en;
        logic [5:0]    r_addr;
        logic [DW-1:0] exp_q;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.clear = 1'b0;
        bus_a.conv_r_en = 1'b0;
        bus_a.conv_w_en = 1'b0;
        bus_a.conv_w_we = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.clear = 1'b0;
        bus_b.conv_r_en = 1'b0;
        bus_b.conv_w_en = 1'b0;
        bus_b.conv_w_we = 1'b0;
    endtask

    // One clock of port A traffic; outputs are sampled 1 time unit after the edge.
    task automatic cyc_a(input bit w, input bit we, input logic [5:0] wa, input logic [DW-1:0] wd,
                         input bit r, input logic [5:0] ra);
        bus_a.conv_w_en = w;
        bus_a.conv_w_we = we;
        bus_a.conv_w_addr = wa;
        bus_a.conv_w_d = wd;
        bus_a.conv_r_en = r;
        bus_a.conv_r_addr = ra;
        step();
        idle_a();
    endtask

    task automatic cyc_b(input bit w, input logic [6:0] wa, input logic [DW-1:0] wd,
                         input bit r, input logic [6:0] ra);
        bus_b.conv_w_en = w;
        bus_b.conv_w_we = w;
        bus_b.conv_w_addr = wa;
        bus_b.conv_w_d = wd;
        bus_b.conv_r_en = r;
        bus_b.conv_r_addr = ra;
        step();
        idle_b();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;
        logic [DW-1:0] seed;
        logic [DW-1:0] relu;

        idle_a();
        idle_b();
        bus_a.conv_r_addr = '0; bus_a.conv_w_addr = '0; bus_a.conv_w_d = '0;
        bus_b.conv_r_addr = '0; bus_b.conv_w_addr = '0; bus_b.conv_w_d = '0;

        // Vector table: {w_en, w_we, w_addr, w_d, r_en, r_addr, expected q}
        vecs[0]  = '{1'b1, 1'b1, 6'd5,  16'h7FFF, 1'b0, 6'd0,  16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 6'd6,  16'h8000, 1'b0, 6'd0,  16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd5,  16'h7FFF};
        vecs[3]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd6,  16'h8000};
        vecs[4]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h8000};
        vecs[5]  = '{1'b1, 1'b1, 6'd9,  16'h0003, 1'b1, 6'd6,  16'h8000};
        vecs[6]  = '{1'b1, 1'b1, 6'd9,  16'hFFFC, 1'b1, 6'd9,  BYPASS ? 16'hFFFC : 16'h0003};
        vecs[7]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd9,  16'hFFFC};
        vecs[8]  = '{1'b1, 1'b1, 6'd10, 16'h1234, 1'b1, 6'd5,  16'h7FFF};
        vecs[9]  = '{1'b1, 1'b0, 6'd10, 16'hAAAA, 1'b1, 6'd10, 16'h1234};
        vecs[10] = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd10, 16'h1234};
        vecs[11] = '{1'b1, 1'b1, 6'd63, 16'h00FF, 1'b1, 6'd0,  16'h0000};
        vecs[12] = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd63, 16'h00FF};

        // Reset state, then count busy cycles after release.
        step(); step(); step();
        check("rst_q", 32'(bus_a.conv_r_q), 32'h0);
        check("rst_err", 32'(bus_a.acc_err), 32'h0);
        check("rst_busy", 32'(bus_a.busy), 32'h1);
        check("rst_busy_b", 32'(bus_b.busy), 32'h1);
        reset = 1'b1;
        cnt = 0;
        guard = 0;
        do begin
            step();
            cnt++;
            guard++;
        end while (bus_a.busy && guard < 200);
        check("rst_busy_cycles", 32'(cnt), 32'd64);
        $display("reset release: busy for %0d cycles", cnt);
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'(i));
            check("rst_clear_rd", 32'(bus_a.conv_r_q), 32'h0);
        end
        check("rst_err_after", 32'(bus_a.acc_err), 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            cyc_a(vecs[i].w_en, vecs[i].w_we, vecs[i].w_addr, vecs[i].w_d, vecs[i].r_en, vecs[i].r_addr);
            $display("vec %0d: w_en=%0b we=%0b wa=%0d wd=%h r_en=%0b ra=%0d q=%h",
                     i, vecs[i].w_en, vecs[i].w_we, vecs[i].w_addr, vecs[i].w_d,
                     vecs[i].r_en, vecs[i].r_addr, bus_a.conv_r_q);
            check("vec_q", 32'(bus_a.conv_r_q), 32'(vecs[i].exp_q));
        end
        check("vec_err", 32'(bus_a.acc_err), 32'h0);

        // Relu-style in-place pass over a seeded map.
        for (int i = 0; i < 64; i++) begin
            seed = (i % 3 == 0) ? DW'(-i) : (i % 3 == 1) ? DW'(0) : DW'(i);
            cyc_a(1'b1, 1'b1, 6'(i), seed, 1'b0, 6'd0);
        end
        for (int i = 0; i < 64; i++) begin
            seed = (i % 3 == 0) ? DW'(-i) : (i % 3 == 1) ? DW'(0) : DW'(i);
            cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'(i));
            check("relu_seed_rd", 32'(bus_a.conv_r_q), 32'(seed));
            relu = $signed(bus_a.conv_r_q) < 0 ? '0 : bus_a.conv_r_q;
            cyc_a(1'b1, 1'b1, 6'(i), relu, 1'b0, 6'd0);
        end
        for (int i = 0; i < 64; i++) begin
            model[i] = (i % 3 == 2) ? DW'(i) : DW'(0);
            cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'(i));
            check("relu_result", 32'(bus_a.conv_r_q), 32'(model[i]));
        end
        check("relu_err", 32'(bus_a.acc_err), 32'h0);
        $display("relu pass done over 64 entries");

        // Random traffic against the array model.
        cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'd2);
        q_exp = model[2];
        check("rand_start", 32'(bus_a.conv_r_q), 32'(q_exp));
        for (int t = 0; t < 400; t++) begin
            bit w, we, r;
            logic [5:0] wa, ra;
            logic [DW-1:0] wd;
            w  = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 3) != 0);
            r  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                wa = 6'($urandom_range(0, 3));
                ra = 6'($urandom_range(0, 3));
            end else begin
                wa = 6'($urandom);
                ra = 6'($urandom);
            end
            wd = DW'($urandom);
            cyc_a(w, we, wa, wd, r, ra);
            if (r) q_exp = (w && we && wa == ra && BYPASS) ? wd : model[ra];
            if (w && we) model[wa] = wd;
            check("rand_q", 32'(bus_a.conv_r_q), 32'(q_exp));
        end
        check("rand_err", 32'(bus_a.acc_err), 32'h0);
        $display("random traffic: 400 cycles");

        // Clear pulse, restart 10 cycles later, access attempts while busy.
        cyc_a(1'b1, 1'b1, 6'd3, 16'h5A5A, 1'b0, 6'd0);
        cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'd3);
        check("pre_clear_rd", 32'(bus_a.conv_r_q), 32'h5A5A);
        bus_a.clear = 1'b1;
        step();
        bus_a.clear = 1'b0;
        cnt = bus_a.busy ? 1 : 0;
        for (int k = 1; k < 10; k++) begin
            step();
            if (bus_a.busy) cnt++;
        end
        bus_a.clear = 1'b1;
        step();
        bus_a.clear = 1'b0;
        if (bus_a.busy) cnt++;
        guard = 0;
        while (bus_a.busy && guard < 200) begin
            if (guard == 5) begin
                bus_a.conv_w_en = 1'b1;
                bus_a.conv_w_we = 1'b1;
                bus_a.conv_w_addr = 6'd3;
                bus_a.conv_w_d = 16'h1234;
                bus_a.conv_r_en = 1'b1;
                bus_a.conv_r_addr = 6'd3;
            end
            step();
            idle_a();
            guard++;
            if (guard == 6) check("busy_rd_q", 32'(bus_a.conv_r_q), 32'h0);
            if (bus_a.busy) cnt++;
        end
        check("clear_busy_cycles", 32'(cnt), 32'd74);
        check("busy_access_err", 32'(bus_a.acc_err), 32'h1);
        $display("clear with restart: busy for %0d cycles", cnt);
        for (int i = 0; i < 64; i++) begin
            cyc_a(1'b0, 1'b0, 6'd0, '0, 1'b1, 6'(i));
            check("clear_rd", 32'(bus_a.conv_r_q), 32'h0);
        end
        check("err_sticky", 32'(bus_a.acc_err), 32'h1);

        // Out-of-range accesses on the 75-entry instance.
        check("b_idle", 32'(bus_b.busy), 32'h0);
        check("b_err0", 32'(bus_b.acc_err), 32'h0);
        cyc_b(1'b1, 7'd74, 16'h0BAD, 1'b0, 7'd0);
        cyc_b(1'b0, 7'd0, '0, 1'b1, 7'd74);
        check("b_rd_last", 32'(bus_b.conv_r_q), 32'h0BAD);
        check("b_err_legal", 32'(bus_b.acc_err), 32'h0);
        cyc_b(1'b1, 7'd80, 16'h1111, 1'b0, 7'd0);
        check("b_oor_wr_err", 32'(bus_b.acc_err), 32'h1);
        cyc_b(1'b0, 7'd0, '0, 1'b1, 7'd80);
        check("b_oor_rd_q", 32'(bus_b.conv_r_q), 32'h0);
        for (int i = 0; i < 75; i++) begin
            cyc_b(1'b0, 7'd0, '0, 1'b1, 7'(i));
            check("b_array", 32'(bus_b.conv_r_q), (i == 74) ? 32'h0BAD : 32'h0);
        end
        $display("out-of-range check on 75-entry instance done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
